// File: rtl/qed_dup_sequencer.sv
// SQED producer: passes original instructions to decode while queueing them, then
// replays the queue as register/memory-remapped duplicates and raises the check qualifiers.
module qed_dup_sequencer #(
  parameter int DEPTH      = 16,
  parameter int REG_OFFSET = 16,
  parameter int MEM_OFFSET = 32,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ifu_inst,
  input  logic             ifu_valid,
  input  logic             exec_dup,
  input  logic             stall,
  input  logic             rob_empty,
  output logic             ifu_ready,
  output logic [31:0]      inst_out,
  output logic             inst_out_valid,
  output logic             is_dup,
  output logic [CNT_W-1:0] num_orig_insts,
  output logic [CNT_W-1:0] num_dup_insts,
  output logic             wait_till_commit,
  output logic             chk_en
);

  localparam int          PTR_W   = $clog2(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [6:0]  OPC_OP  = 7'b0110011;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI = 7'b0110111;
  localparam logic [6:0]  OPC_LD  = 7'b0000011;
  localparam logic [6:0]  OPC_ST  = 7'b0100011;
  localparam logic [4:0]  REG_ADJ = 5'(REG_OFFSET);
  localparam logic [11:0] IMM_ADJ = 12'(4 * MEM_OFFSET);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_ORIG  = 2'd0,
    ST_DUP   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_supported(input logic [31:0] inst);
    case (inst[6:0])
      OPC_OP, OPC_IMM, OPC_LUI, OPC_LD, OPC_ST: is_supported = 1'b1;
      default:                                  is_supported = 1'b0;
    endcase
  endfunction

  // x0 must stay x0 so the duplicate keeps the hardwired-zero semantics.
  function automatic logic [4:0] remap(input logic [4:0] r);
    if (r != 5'd0) remap = r + REG_ADJ;
    else           remap = r;
  endfunction

  function automatic logic [31:0] xform(input logic [31:0] inst);
    logic [11:0] imm;
    imm   = 12'd0;
    xform = inst;
    case (inst[6:0])
      OPC_OP: begin
        xform[11:7]  = remap(inst[11:7]);
        xform[19:15] = remap(inst[19:15]);
        xform[24:20] = remap(inst[24:20]);
      end
      OPC_IMM: begin
        xform[11:7]  = remap(inst[11:7]);
        xform[19:15] = remap(inst[19:15]);
      end
      OPC_LUI: xform[11:7] = remap(inst[11:7]);
      OPC_LD: begin
        imm          = inst[31:20] + IMM_ADJ;
        xform[31:20] = imm;
        xform[11:7]  = remap(inst[11:7]);
        xform[19:15] = remap(inst[19:15]);
      end
      OPC_ST: begin
        imm          = {inst[31:25], inst[11:7]} + IMM_ADJ;
        xform[31:25] = imm[11:5];
        xform[11:7]  = imm[4:0];
        xform[19:15] = remap(inst[19:15]);
        xform[24:20] = remap(inst[24:20]);
      end
      default: xform = inst;
    endcase
  endfunction

  state_t             state_r, state_nxt_s;
  logic [PTR_W-1:0]   head_r, tail_r;
  logic [CNT_W-1:0]   num_orig_r, num_dup_r, num_orig_nxt_s;
  logic [31:0]        queue_r [DEPTH];
  logic [31:0]        inst_out_r, inst_out_nxt_s;
  logic               inst_out_valid_r, valid_nxt_s;
  logic               is_dup_r, is_dup_nxt_s;
  logic               ifu_ready_r, wait_r, chk_en_r;
  logic               accept_s, push_s, pop_s;

  assign accept_s       = ifu_valid & ifu_ready_r & ~stall & (state_r == ST_ORIG);
  assign push_s         = accept_s & is_supported(ifu_inst);
  assign num_orig_nxt_s = push_s ? (num_orig_r + CNT_ONE) : num_orig_r;

  // State register plus all registered datapath and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= ST_ORIG;
      head_r           <= '0;
      tail_r           <= '0;
      num_orig_r       <= '0;
      num_dup_r        <= '0;
      inst_out_r       <= NOP;
      inst_out_valid_r <= 1'b0;
      is_dup_r         <= 1'b0;
      ifu_ready_r      <= 1'b1;
      wait_r           <= 1'b0;
      chk_en_r         <= 1'b0;
      for (int i = 0; i < DEPTH; i++) queue_r[i] <= 32'd0;
    end else begin
      state_r          <= state_nxt_s;
      num_orig_r       <= num_orig_nxt_s;
      inst_out_r       <= inst_out_nxt_s;
      inst_out_valid_r <= valid_nxt_s;
      is_dup_r         <= is_dup_nxt_s;
      ifu_ready_r      <= (state_nxt_s == ST_ORIG);
      wait_r           <= (state_nxt_s == ST_DRAIN) || (state_nxt_s == ST_DONE);
      chk_en_r         <= (state_nxt_s == ST_DONE);
      if (push_s) begin
        queue_r[tail_r] <= ifu_inst;
        tail_r          <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r    <= head_r + PTR_W'(1);
        num_dup_r <= num_dup_r + CNT_ONE;
      end
    end
  end

  // Next-state logic; a stalled cycle never advances the phase.
  always_comb begin
    state_nxt_s = state_r;
    if (stall) begin
      state_nxt_s = state_r;
    end else begin
      case (state_r)
        ST_ORIG: begin
          if ((exec_dup && (num_orig_nxt_s != '0)) || (num_orig_nxt_s == CNT_FULL))
            state_nxt_s = ST_DUP;
          else
            state_nxt_s = ST_ORIG;
        end
        ST_DUP: begin
          if ((num_dup_r + CNT_ONE) == num_orig_r) state_nxt_s = ST_DRAIN;
          else                                     state_nxt_s = ST_DUP;
        end
        ST_DRAIN: begin
          if (rob_empty) state_nxt_s = ST_DONE;
          else           state_nxt_s = ST_DRAIN;
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_ORIG;
      endcase
    end
  end

  // Output logic: next values of the registered decode-side outputs and the queue pop.
  always_comb begin
    inst_out_nxt_s = inst_out_r;
    valid_nxt_s    = inst_out_valid_r;
    is_dup_nxt_s   = is_dup_r;
    pop_s          = 1'b0;
    if (stall) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_ORIG: begin
          is_dup_nxt_s = 1'b0;
          if (accept_s) begin
            inst_out_nxt_s = push_s ? ifu_inst : NOP;
            valid_nxt_s    = 1'b1;
          end else begin
            valid_nxt_s = 1'b0;
          end
        end
        ST_DUP: begin
          inst_out_nxt_s = xform(queue_r[head_r]);
          valid_nxt_s    = 1'b1;
          is_dup_nxt_s   = 1'b1;
          pop_s          = 1'b1;
        end
        default: begin
          valid_nxt_s  = 1'b0;
          is_dup_nxt_s = 1'b0;
        end
      endcase
    end
  end

  assign ifu_ready        = ifu_ready_r;
  assign inst_out         = inst_out_r;
  assign inst_out_valid   = inst_out_valid_r;
  assign is_dup           = is_dup_r;
  assign num_orig_insts   = num_orig_r;
  assign num_dup_insts    = num_dup_r;
  assign wait_till_commit = wait_r;
  assign chk_en           = chk_en_r;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Randomized bench for qed_dup_sequencer: instructions are described as field records,
// and originals/duplicates are encoded from those records by a reference model.
module tb_qed_dup_sequencer;
  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst, ifu_valid, exec_dup, stall, rob_empty;
  logic [31:0]      ifu_inst;
  logic             ifu_ready, inst_out_valid, is_dup, wait_till_commit, chk_en;
  logic [31:0]      inst_out;
  logic [CNT_W-1:0] num_orig_insts, num_dup_insts;

  qed_dup_sequencer #(.DEPTH(DEPTH), .REG_OFFSET(16), .MEM_OFFSET(32)) dut (
    .clk(clk), .rst(rst), .ifu_inst(ifu_inst), .ifu_valid(ifu_valid),
    .exec_dup(exec_dup), .stall(stall), .rob_empty(rob_empty),
    .ifu_ready(ifu_ready), .inst_out(inst_out), .inst_out_valid(inst_out_valid),
    .is_dup(is_dup), .num_orig_insts(num_orig_insts), .num_dup_insts(num_dup_insts),
    .wait_till_commit(wait_till_commit), .chk_en(chk_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // kind: 0 OP, 1 OP-IMM, 2 LUI, 3 LOAD, 4 STORE, 5 unsupported (imm selects which)
  typedef struct {
    int kind; int rd; int rs1; int rs2; int imm; int f3; int f7;
  } rec_t;

  logic [32:0] obs_q[$];
  logic [32:0] exp_q[$];
  logic [31:0] prev_inst;
  logic [CNT_W-1:0] prev_ndup;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] enc(input rec_t r);
    logic [31:0] unsup [4];
    logic [11:0] i12;
    logic [31:0] w;
    unsup[0] = 32'h0000_0063; unsup[1] = 32'h0000_006f;
    unsup[2] = 32'h0000_0073; unsup[3] = 32'h0000_0017;
    i12 = r.imm[11:0];
    case (r.kind)
      0: w = {r.f7[6:0], r.rs2[4:0], r.rs1[4:0], r.f3[2:0], r.rd[4:0], 7'h33};
      1: w = {i12, r.rs1[4:0], r.f3[2:0], r.rd[4:0], 7'h13};
      2: w = {r.imm[19:0], r.rd[4:0], 7'h37};
      3: w = {i12, r.rs1[4:0], 3'b010, r.rd[4:0], 7'h03};
      4: w = {i12[11:5], r.rs2[4:0], r.rs1[4:0], 3'b010, i12[4:0], 7'h23};
      default: w = unsup[r.imm % 4];
    endcase
    return w;
  endfunction

  // Duplicate: every register moves to the upper bank except x0; memory moves 32 words up.
  function automatic rec_t dup_of(input rec_t r);
    rec_t d;
    d = r;
    d.rd  = (r.rd  == 0) ? 0 : r.rd  + 16;
    d.rs1 = (r.rs1 == 0) ? 0 : r.rs1 + 16;
    d.rs2 = (r.rs2 == 0) ? 0 : r.rs2 + 16;
    if (r.kind == 3 || r.kind == 4) d.imm = r.imm + 4 * 32;
    return d;
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.kind = $urandom_range(0, 5);
    r.rd  = $urandom_range(0, 15);
    r.rs1 = $urandom_range(0, 15);
    r.rs2 = $urandom_range(0, 15);
    r.f3  = $urandom_range(0, 7);
    r.f7  = ($urandom_range(0, 1) == 1) ? 32 : 0;
    case (r.kind)
      1:       r.imm = $urandom_range(0, 4095);
      2:       r.imm = $urandom_range(0, 1048575);
      3, 4:    r.imm = 4 * $urandom_range(0, 31);
      default: r.imm = $urandom_range(0, 3);
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst && stall) begin
      check_eq("hold_inst", inst_out, prev_inst);
      check_eq("hold_ndup", num_dup_insts, prev_ndup);
    end
    if (!rst && !stall && inst_out_valid) obs_q.push_back({is_dup, inst_out});
    prev_inst = inst_out;
    prev_ndup = num_dup_insts;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, ifu_ready, 1'b1);
    check_eq({tag, "_inst"}, inst_out, 32'h0000_0013);
    check_eq({tag, "_valid"}, inst_out_valid, 1'b0);
    check_eq({tag, "_isdup"}, is_dup, 1'b0);
    check_eq({tag, "_norig"}, num_orig_insts, 5'd0);
    check_eq({tag, "_ndup"}, num_dup_insts, 5'd0);
    check_eq({tag, "_wait"}, wait_till_commit, 1'b0);
    check_eq({tag, "_chk"}, chk_en, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; ifu_valid = 1'b0; exec_dup = 1'b0; stall = 1'b0;
    rob_empty = 1'b0; ifu_inst = 32'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Feeds n supported originals (unsupported ones interleaved when random), replays, drains.
  task automatic run_seq(input int n, input bit force_dup, input bit directed);
    rec_t orig[$];
    rec_t dir[3];
    rec_t r;
    int sent, guard;
    dir[0] = '{1, 1, 0, 0, 7, 0, 0};
    dir[1] = '{1, 3, 1, 0, 7, 0, 0};
    dir[2] = '{3, 7, 0, 0, 15, 2, 0};
    obs_q.delete(); exp_q.delete();
    do_reset();
    check_reset("rst");
    exec_dup = 1'b1;
    tick();
    exec_dup = 1'b0;
    check_eq("idle_exec_ready", ifu_ready, 1'b1);
    check_eq("idle_exec_norig", num_orig_insts, 5'd0);
    sent = 0; guard = 0;
    while (sent < n && guard < 1000) begin
      r = directed ? dir[sent] : rand_rec();
      ifu_inst  = enc(r);
      ifu_valid = 1'b1;
      exec_dup  = !force_dup && (r.kind != 5) && (sent == n - 1);
      do begin
        stall = directed ? 1'b0 : ($urandom_range(0, 4) == 0);
        check_eq("ready_orig", ifu_ready, 1'b1);
        tick();
        guard++;
      end while (stall && guard < 1000);
      exp_q.push_back({1'b0, (r.kind == 5) ? 32'h0000_0013 : enc(r)});
      if (r.kind != 5) begin
        orig.push_back(r);
        sent++;
      end
    end
    exec_dup = 1'b0;
    ifu_inst = enc(rand_rec());
    check_eq("ready_dup", ifu_ready, 1'b0);
    foreach (orig[i]) exp_q.push_back({1'b1, enc(dup_of(orig[i]))});
    guard = 0;
    while (obs_q.size() < exp_q.size() && guard < 200) begin
      stall = directed ? 1'b0 : ($urandom_range(0, 3) == 0);
      tick();
      guard++;
    end
    ifu_valid = 1'b0;
    stall = 1'b0;
    tick();
    check_eq("stream_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_eq($sformatf("stream[%0d]", i), obs_q[i], exp_q[i]);
    if (directed && obs_q.size() == 6) begin
      check_eq("t1_dup0", obs_q[3], {1'b1, 32'h0070_0893});
      check_eq("t1_dup1", obs_q[4], {1'b1, 32'h0078_8993});
      check_eq("t1_dup2", obs_q[5], {1'b1, 32'h08f0_2b83});
    end
    check_eq("drain_valid", inst_out_valid, 1'b0);
    check_eq("num_orig", num_orig_insts, n);
    check_eq("num_dup", num_dup_insts, n);
    repeat (5) tick();
    check_eq("drain_wait", wait_till_commit, 1'b1);
    check_eq("drain_chk", chk_en, 1'b0);
    rob_empty = 1'b1;
    tick();
    check_eq("done_chk", chk_en, 1'b1);
    repeat (3) tick();
    check_eq("done_chk_hold", chk_en, 1'b1);
    check_eq("done_wait", wait_till_commit, 1'b1);
    check_eq("done_ready", ifu_ready, 1'b0);
    check_eq("done_valid", inst_out_valid, 1'b0);
  endtask

  // Abort partway through the duplicate phase.
  task automatic reset_mid_dup();
    rec_t r;
    int guard;
    obs_q.delete();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r = rand_rec();
      if (r.kind == 5) r.kind = 0;
      ifu_inst = enc(r); ifu_valid = 1'b1; exec_dup = (i == 3);
      tick();
    end
    ifu_valid = 1'b0; exec_dup = 1'b0;
    guard = 0;
    while (obs_q.size() < 6 && guard < 50) begin
      tick();
      guard++;
    end
    check_eq("mid_ndup", num_dup_insts, 5'd2);
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0;
    tick();
    check_reset("mid_after");
  endtask

  initial begin
    prev_inst = 32'd0;
    prev_ndup = '0;
    run_seq(3, 1'b0, 1'b1);
    run_seq(16, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) run_seq($urandom_range(1, 15), 1'b0, 1'b0);
    reset_mid_dup();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
